// File: rtl/mem_writeback_stage.sv
// Memory/writeback stage: ALU results go straight to the register-file write port, loads issue one
// aligned read, then sign/zero-extend the selected lane. Optional LOAD_TIMEOUT_EN aborts a load after 255 cycles with no response.
//
// state    | meaning
// IDLE     | no op in flight, ready for a new op
// MEM_REQ  | read request presented, waiting for mem_req_ready
// MEM_WAIT | request accepted, waiting for mem_rsp_valid
// WB       | register-file write (or fault pulse) presented, ready for a new op
module mem_writeback_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [4:0]  in_rd,
  input  logic [31:0] in_alu_result,
  input  logic        in_is_load,
  input  logic [2:0]  in_funct3,
  input  logic        in_reg_write,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic [4:0]  write_reg,
  output logic [31:0] write_data,
  output logic        cs_reg_write,
  output logic        load_fault
);

  typedef enum logic [1:0] {IDLE, MEM_REQ, MEM_WAIT, WB} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_mem_req_valid, w_mem_req_valid_nxt;
  logic [31:0] r_mem_addr, w_mem_addr_nxt;
  logic [4:0]  r_write_reg, w_write_reg_nxt;
  logic [31:0] r_write_data, w_write_data_nxt;
  logic        r_cs_reg_write, w_cs_reg_write_nxt;
  logic        r_load_fault, w_load_fault_nxt;
  logic [4:0]  r_rd, w_rd_nxt;
  logic [2:0]  r_funct3, w_funct3_nxt;
  logic [1:0]  r_addr_lo, w_addr_lo_nxt;

  logic        w_accept;
  logic        w_load_bad;
  logic        w_timeout;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign in_ready = reset & ((r_state == IDLE) | (r_state == WB));
  assign w_accept = in_valid & in_ready;

  always_comb begin
    w_load_bad = 1'b0;
    case (in_funct3)
      3'b000, 3'b100: w_load_bad = 1'b0;
      3'b001, 3'b101: w_load_bad = in_alu_result[0];
      3'b010:         w_load_bad = |in_alu_result[1:0];
      default:        w_load_bad = 1'b1;
    endcase
  end

  always_comb begin
    w_byte = mem_rsp_data[{r_addr_lo, 3'b000} +: 8];
    w_half = r_addr_lo[1] ? mem_rsp_data[31:16] : mem_rsp_data[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b100:  w_load_data = {24'd0, w_byte};
      3'b101:  w_load_data = {16'd0, w_half};
      default: w_load_data = mem_rsp_data;
    endcase
  end

`ifdef LOAD_TIMEOUT_EN
  logic [7:0] r_timeout_cnt;

  // Reloaded outside MEM_WAIT so the 255th waiting cycle sees the terminal count.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_timeout_cnt <= 8'd254;
    end else if (r_state != MEM_WAIT) begin
      r_timeout_cnt <= 8'd254;
    end else if (r_timeout_cnt != 8'd0) begin
      r_timeout_cnt <= r_timeout_cnt - 8'd1;
    end
  end

  assign w_timeout = (r_timeout_cnt == 8'd0);
`else
  assign w_timeout = 1'b0;
`endif

  always_comb begin
    w_state_nxt         = r_state;
    w_mem_req_valid_nxt = r_mem_req_valid;
    w_mem_addr_nxt      = r_mem_addr;
    w_write_reg_nxt     = r_write_reg;
    w_write_data_nxt    = r_write_data;
    w_cs_reg_write_nxt  = 1'b0;
    w_load_fault_nxt    = 1'b0;
    w_rd_nxt            = r_rd;
    w_funct3_nxt        = r_funct3;
    w_addr_lo_nxt       = r_addr_lo;
    case (r_state)
      IDLE, WB: begin
        if (w_accept) begin
          if (!in_is_load) begin
            w_state_nxt        = WB;
            w_write_reg_nxt    = in_rd;
            w_write_data_nxt   = in_alu_result;
            w_cs_reg_write_nxt = in_reg_write & (in_rd != 5'd0);
          end else if (w_load_bad) begin
            w_state_nxt      = WB;
            w_write_reg_nxt  = in_rd;
            w_load_fault_nxt = 1'b1;
          end else begin
            w_state_nxt         = MEM_REQ;
            w_mem_req_valid_nxt = 1'b1;
            w_mem_addr_nxt      = {in_alu_result[31:2], 2'b00};
            w_rd_nxt            = in_rd;
            w_funct3_nxt        = in_funct3;
            w_addr_lo_nxt       = in_alu_result[1:0];
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      MEM_REQ: begin
        if (mem_req_ready) begin
          w_state_nxt         = MEM_WAIT;
          w_mem_req_valid_nxt = 1'b0;
        end
      end
      MEM_WAIT: begin
        if (mem_rsp_valid) begin
          w_state_nxt        = WB;
          w_write_reg_nxt    = r_rd;
          w_write_data_nxt   = w_load_data;
          w_cs_reg_write_nxt = (r_rd != 5'd0);
        end else if (w_timeout) begin
          w_state_nxt      = WB;
          w_write_reg_nxt  = r_rd;
          w_load_fault_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state         <= IDLE;
      r_mem_req_valid <= 1'b0;
      r_mem_addr      <= 32'd0;
      r_write_reg     <= 5'd0;
      r_write_data    <= 32'd0;
      r_cs_reg_write  <= 1'b0;
      r_load_fault    <= 1'b0;
      r_rd            <= 5'd0;
      r_funct3        <= 3'd0;
      r_addr_lo       <= 2'd0;
    end else begin
      r_state         <= w_state_nxt;
      r_mem_req_valid <= w_mem_req_valid_nxt;
      r_mem_addr      <= w_mem_addr_nxt;
      r_write_reg     <= w_write_reg_nxt;
      r_write_data    <= w_write_data_nxt;
      r_cs_reg_write  <= w_cs_reg_write_nxt;
      r_load_fault    <= w_load_fault_nxt;
      r_rd            <= w_rd_nxt;
      r_funct3        <= w_funct3_nxt;
      r_addr_lo       <= w_addr_lo_nxt;
    end
  end

  assign mem_req_valid = r_mem_req_valid;
  assign mem_addr      = r_mem_addr;
  assign write_reg     = r_write_reg;
  assign write_data    = r_write_data;
  assign cs_reg_write  = r_cs_reg_write;
  assign load_fault    = r_load_fault;

endmodule

// File: tb/tb_mem_writeback_stage.sv
// Directed bench for mem_writeback_stage: non-load writeback, load lanes/extension, faults, reset abort.
// Define LOAD_TIMEOUT_EN to also exercise the MEM_WAIT timeout.
module tb_mem_writeback_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_rd = 5'd0;
  logic [31:0] in_alu_result = 32'd0;
  logic        in_is_load = 1'b0;
  logic [2:0]  in_funct3 = 3'd0;
  logic        in_reg_write = 1'b0;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = 32'd0;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        cs_reg_write;
  logic        load_fault;

  int n_checks = 0;
  int n_errors = 0;

  mem_writeback_stage u_dut (
    .clk           (clk),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_rd         (in_rd),
    .in_alu_result (in_alu_result),
    .in_is_load    (in_is_load),
    .in_funct3     (in_funct3),
    .in_reg_write  (in_reg_write),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_addr      (mem_addr),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_data  (mem_rsp_data),
    .write_reg     (write_reg),
    .write_data    (write_data),
    .cs_reg_write  (cs_reg_write),
    .load_fault    (load_fault)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s act=%h exp=%h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_op(input logic ld, input logic [4:0] rd, input logic [2:0] f3,
                          input logic [31:0] val, input logic rw);
    in_valid      = 1'b1;
    in_is_load    = ld;
    in_rd         = rd;
    in_funct3     = f3;
    in_alu_result = val;
    in_reg_write  = rw;
  endtask

  // Accept a load, grant the request at once, respond on the first MEM_WAIT cycle; returns in WB.
  task automatic run_load(input logic [4:0] rd, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] rsp);
    drive_op(1'b1, rd, f3, addr, 1'b1);
    tick();
    in_valid      = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = rsp;
    tick();
    mem_rsp_valid = 1'b0;
  endtask

  typedef struct {
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rsp;
    logic [31:0] exp_data;
    logic        exp_we;
  } load_vec_t;

  load_vec_t lv[7];

  initial begin
    lv[0] = '{5'd7,  3'b000, 32'h0000_1003, 32'h80FF_0000, 32'hFFFF_FF80, 1'b1};
    lv[1] = '{5'd8,  3'b100, 32'h0000_1003, 32'h80FF_0000, 32'h0000_0080, 1'b1};
    lv[2] = '{5'd9,  3'b001, 32'h0000_2002, 32'h80FF_0000, 32'hFFFF_80FF, 1'b1};
    lv[3] = '{5'd10, 3'b101, 32'h0000_2002, 32'h80FF_0000, 32'h0000_80FF, 1'b1};
    lv[4] = '{5'd11, 3'b010, 32'h0000_3000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};
    lv[5] = '{5'd12, 3'b000, 32'h0000_1001, 32'h1234_5678, 32'h0000_0056, 1'b1};
    lv[6] = '{5'd0,  3'b001, 32'h0000_1000, 32'h0000_F0F0, 32'hFFFF_F0F0, 1'b0};

    #1 reset = 1'b0;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_req_valid", {31'd0, mem_req_valid}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_write_reg", {27'd0, write_reg}, 32'd0);
    chk("rst_write_data", write_data, 32'd0);
    chk("rst_cs", {31'd0, cs_reg_write}, 32'd0);
    chk("rst_fault", {31'd0, load_fault}, 32'd0);
    #9 reset = 1'b1;
    tick();
    chk("idle_ready", {31'd0, in_ready}, 32'd1);

    drive_op(1'b0, 5'd5, 3'b000, 32'h1234_5678, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("alu_cs", {31'd0, cs_reg_write}, 32'd1);
    chk("alu_reg", {27'd0, write_reg}, 32'd5);
    chk("alu_data", write_data, 32'h1234_5678);
    chk("wb_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("alu_cs_one_cycle", {31'd0, cs_reg_write}, 32'd0);

    drive_op(1'b0, 5'd1, 3'b000, 32'h0000_000A, 1'b1);
    tick();
    chk("b2b_a_cs", {31'd0, cs_reg_write}, 32'd1);
    chk("b2b_a_data", write_data, 32'h0000_000A);
    drive_op(1'b0, 5'd2, 3'b000, 32'h0000_000B, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("b2b_b_cs", {31'd0, cs_reg_write}, 32'd1);
    chk("b2b_b_reg", {27'd0, write_reg}, 32'd2);
    chk("b2b_b_data", write_data, 32'h0000_000B);
    tick();
    chk("b2b_end_cs", {31'd0, cs_reg_write}, 32'd0);

    drive_op(1'b0, 5'd0, 3'b000, 32'h5555_AAAA, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("rd0_cs", {31'd0, cs_reg_write}, 32'd0);
    drive_op(1'b0, 5'd3, 3'b000, 32'h0000_0033, 1'b0);
    tick();
    in_valid = 1'b0;
    chk("nowrite_cs", {31'd0, cs_reg_write}, 32'd0);
    tick();

    // Stalled request: hold mem_req_ready low, also inject a stray response.
    drive_op(1'b1, 5'd7, 3'b000, 32'h0000_1003, 1'b1);
    tick();
    in_valid = 1'b0;
    chk("req_busy_ready", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      chk("stall_req_valid", {31'd0, mem_req_valid}, 32'd1);
      chk("stall_mem_addr", mem_addr, 32'h0000_1000);
      mem_rsp_valid = (i == 1);
      mem_rsp_data  = 32'hFFFF_FFFF;
      tick();
      chk("stall_stray_cs", {31'd0, cs_reg_write}, 32'd0);
    end
    mem_rsp_valid = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    chk("wait_req_valid", {31'd0, mem_req_valid}, 32'd0);
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'h80FF_0000;
    tick();
    mem_rsp_valid = 1'b0;
    chk("stall_lb_cs", {31'd0, cs_reg_write}, 32'd1);
    chk("stall_lb_data", write_data, 32'hFFFF_FF80);
    tick();
    chk("stall_lb_cs_off", {31'd0, cs_reg_write}, 32'd0);

    foreach (lv[i]) begin
      run_load(lv[i].rd, lv[i].f3, lv[i].addr, lv[i].rsp);
      chk($sformatf("ld%0d_cs", i), {31'd0, cs_reg_write}, {31'd0, lv[i].exp_we});
      chk($sformatf("ld%0d_data", i), write_data, lv[i].exp_data);
      if (lv[i].exp_we)
        chk($sformatf("ld%0d_reg", i), {27'd0, write_reg}, {27'd0, lv[i].rd});
      chk($sformatf("ld%0d_addr", i), mem_addr, {lv[i].addr[31:2], 2'b00});
      tick();
      chk($sformatf("ld%0d_cs_off", i), {31'd0, cs_reg_write}, 32'd0);
    end

    // Misaligned and unsupported loads fault without touching memory.
    for (int i = 0; i < 3; i++) begin
      case (i)
        0:       drive_op(1'b1, 5'd4, 3'b001, 32'h0000_2001, 1'b1);
        1:       drive_op(1'b1, 5'd4, 3'b010, 32'h0000_2002, 1'b1);
        default: drive_op(1'b1, 5'd4, 3'b011, 32'h0000_2000, 1'b1);
      endcase
      tick();
      in_valid = 1'b0;
      chk($sformatf("bad%0d_fault", i), {31'd0, load_fault}, 32'd1);
      chk($sformatf("bad%0d_cs", i), {31'd0, cs_reg_write}, 32'd0);
      chk($sformatf("bad%0d_req", i), {31'd0, mem_req_valid}, 32'd0);
      tick();
      chk($sformatf("bad%0d_fault_off", i), {31'd0, load_fault}, 32'd0);
      chk($sformatf("bad%0d_req_off", i), {31'd0, mem_req_valid}, 32'd0);
      chk($sformatf("bad%0d_idle", i), {31'd0, in_ready}, 32'd1);
    end

    // Reset while waiting for a response abandons the load.
    drive_op(1'b1, 5'd6, 3'b010, 32'h0000_4000, 1'b1);
    tick();
    in_valid      = 1'b0;
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    reset = 1'b0;
    #2;
    chk("rstw_ready", {31'd0, in_ready}, 32'd0);
    chk("rstw_req", {31'd0, mem_req_valid}, 32'd0);
    chk("rstw_data", write_data, 32'd0);
    #3 reset = 1'b1;
    mem_rsp_valid = 1'b1;
    mem_rsp_data  = 32'hCAFE_F00D;
    tick();
    mem_rsp_valid = 1'b0;
    chk("rstw_cs", {31'd0, cs_reg_write}, 32'd0);
    chk("rstw_idle", {31'd0, in_ready}, 32'd1);
    tick();
    chk("rstw_cs2", {31'd0, cs_reg_write}, 32'd0);
    chk("rstw_data2", write_data, 32'd0);

`ifdef LOAD_TIMEOUT_EN
    begin
      int n_wait;
      drive_op(1'b1, 5'd9, 3'b010, 32'h0000_5000, 1'b1);
      tick();
      in_valid      = 1'b0;
      mem_req_ready = 1'b1;
      tick();
      mem_req_ready = 1'b0;
      n_wait = 0;
      while (load_fault !== 1'b1 && n_wait < 300) begin
        tick();
        n_wait++;
      end
      chk("to_cycles", n_wait, 32'd255);
      chk("to_cs", {31'd0, cs_reg_write}, 32'd0);
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = 32'h1111_2222;
      tick();
      mem_rsp_valid = 1'b0;
      chk("to_fault_off", {31'd0, load_fault}, 32'd0);
      chk("to_idle", {31'd0, in_ready}, 32'd1);
      chk("to_stray_cs", {31'd0, cs_reg_write}, 32'd0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
